// File: rtl/serv_ibus_mem_if_pkg.sv
// serv_ibus_mem_if_pkg: shared types and constants for the
// instruction-fetch bridge between the core ibus and a split memory port.
package serv_ibus_mem_if_pkg;

    // Width of the saturating WAIT-state timeout counter
    localparam int CNT_W = 8;

    // Word handed to the core when a fetch times out (decodes as illegal)
    localparam logic [31:0] ERR_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACK,
        DRAIN_ACK,
        DRAIN
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/serv_ibus_mem_if.sv
// serv_ibus_mem_if: turns each core fetch cycle into one req/gnt +
// rvalid transaction, with abort, timeout and late-response draining.
module serv_ibus_mem_if
    import serv_ibus_mem_if_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          TIMEOUT   = 15,
    parameter logic [31:0] ERR_INSTR = ERR_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_ibus_cyc,
    input  logic [AW-1:0] i_ibus_adr,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_err_timeout
);

    // Counter value seen on the final WAIT cycle before a timeout
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              req_d;
    logic              ack_d;
    logic              err_d;
    logic [31:0]       rdt_d;
    logic [AW-1:0]     addr_d;
    logic [AW-1:0]     adr_aligned;
    logic              timeout;
    logic              unused_adr_lsb;

    assign adr_aligned    = {i_ibus_adr[AW-1:2], 2'b00};
    assign timeout        = (cnt_q == CNT_LAST);
    assign unused_adr_lsb = ^i_ibus_adr[1:0];

    // Next-state and next-output logic; all outputs are registered
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdt_d   = o_ibus_rdt;
        addr_d  = o_mem_addr;
        unique case (state_q)
            IDLE: begin
                if (i_ibus_cyc) begin
                    addr_d  = adr_aligned;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    cnt_d   = '0;
                    state_d = i_ibus_cyc ? WAIT : DRAIN;
                end else if (!i_ibus_cyc) begin
                    state_d = IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = sat_inc(cnt_q);
                if (i_mem_rvalid) begin
                    // Data arriving as the core aborts is simply
                    // consumed; nothing is owed any more.
                    if (i_ibus_cyc) begin
                        rdt_d   = i_mem_rdata;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!i_ibus_cyc) begin
                    state_d = DRAIN;
                end else if (timeout) begin
                    rdt_d   = ERR_INSTR;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DRAIN_ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            DRAIN_ACK: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (i_mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            o_mem_req     <= 1'b0;
            o_ibus_ack    <= 1'b0;
            o_err_timeout <= 1'b0;
            o_ibus_rdt    <= '0;
            o_mem_addr    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            o_mem_req     <= req_d;
            o_ibus_ack    <= ack_d;
            o_err_timeout <= err_d;
            o_ibus_rdt    <= rdt_d;
            o_mem_addr    <= addr_d;
        end
    end

endmodule
